// File: rtl/sram_access_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sram_access_ctrl_if                                       |
// | Brief    : Request/response channel bundle for sram_access_ctrl.     |
// |            master = traffic source / response consumer,              |
// |            slave  = the access controller.                           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface sram_access_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/sram_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sram_access_ctrl                                          |
// | Brief    : valid/ready front-end for a single-port SRAM with 1-cycle |
// |            registered read latency. Zero-fills the array after       |
// |            reset, then passes requests through as raw SRAM strobes   |
// |            and queues read data in a small response FIFO.           |
// | Options  : SRAM_ACC_STAT_EN adds read/write/stall statistics ports.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sram_access_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int RSP_DEPTH  = 3
) (
  input  wire                   clk,
  input  wire                   rst_n,
  sram_access_ctrl_if.slave     bus,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_write_req,
  input  wire  [DATA_WIDTH-1:0] sram_q
`ifdef SRAM_ACC_STAT_EN
  ,
  output logic [31:0]           stat_rd_cnt,
  output logic [31:0]           stat_wr_cnt,
  output logic [31:0]           stat_stall_cnt
`endif
);

  localparam int c_CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int c_PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [c_PTR_W-1:0]    c_LAST_PTR  = c_PTR_W'(RSP_DEPTH - 1);
  localparam logic [c_CNT_W:0]      c_DEPTH_OCC = (c_CNT_W + 1)'(RSP_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_INIT_LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  logic                  r_init_done;
  logic                  r_rd_inflight;

  logic [DATA_WIDTH-1:0] r_fifo [RSP_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;

  logic                  w_req_fire;
  logic                  w_rd_fire;
  logic                  w_push;
  logic                  w_pop;
  logic [c_CNT_W:0]      w_occupancy;
  logic                  w_room;

  function automatic logic [c_PTR_W-1:0] f_ptr_next(input logic [c_PTR_W-1:0] p);
    return (p == c_LAST_PTR) ? '0 : p + c_PTR_W'(1);
  endfunction

  // Reads reserve a FIFO slot at acceptance so an in-flight read always has room
  assign w_occupancy = {1'b0, r_count} + (c_CNT_W + 1)'(r_rd_inflight);
  assign w_room      = (w_occupancy < c_DEPTH_OCC);
  assign w_req_fire  = bus.req_valid & bus.req_ready;
  assign w_rd_fire   = w_req_fire & ~bus.req_write;
  assign w_push      = r_rd_inflight;
  assign w_pop       = bus.rsp_valid & bus.rsp_ready;

  assign bus.rsp_valid = (r_count != '0);
  assign bus.rsp_rdata = r_fifo[r_rd_ptr];
  assign init_done     = r_init_done;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and SRAM/handshake outputs: zero-fill in INIT, passthrough in RUN
  always_comb begin
    w_state_nxt    = r_state;
    bus.req_ready  = 1'b0;
    sram_addr      = r_init_cnt;
    sram_data      = '0;
    sram_write_req = 1'b0;
    case (r_state)
      ST_INIT: begin
        sram_write_req = 1'b1;
        if (r_init_cnt == c_INIT_LAST) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Writes never need a response slot, so only reads are throttled
        bus.req_ready  = bus.req_write | w_room;
        sram_addr      = bus.req_addr;
        sram_data      = bus.req_wdata;
        sram_write_req = bus.req_valid & bus.req_write;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // Zero-fill address counter and completion flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
      if (r_init_cnt == c_INIT_LAST) begin
        r_init_done <= 1'b1;
      end
    end
  end

  // Marks the cycle in which sram_q carries data for an accepted read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_inflight <= 1'b0;
    end else begin
      r_rd_inflight <= w_rd_fire;
    end
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_ptr_next(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Response FIFO storage; contents are meaningless while r_count says empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= sram_q;
    end
  end

`ifdef SRAM_ACC_STAT_EN
  logic w_wr_fire;
  assign w_wr_fire = w_req_fire & bus.req_write;

  // Traffic statistics; stalls only count once the array is in service
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_cnt    <= '0;
      stat_wr_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (w_rd_fire) begin
        stat_rd_cnt <= stat_rd_cnt + 32'd1;
      end
      if (w_wr_fire) begin
        stat_wr_cnt <= stat_wr_cnt + 32'd1;
      end
      if ((r_state == ST_RUN) && bus.req_valid && !bus.req_ready) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
